// File: rtl/hazard_unit_if.sv
// Hazard unit bundle: Decode-stage tags and branch resolve in, stall/flush/forward controls out.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              reg_writeD;
    logic              loadD;
    logic              PCSrcE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output Rs1D, Rs2D, RdD, reg_writeD, loadD, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_count
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, reg_writeD, loadD, PCSrcE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow E/M/W tag pipeline, forwarding selects,
// load-use stall sequencing, branch flush and a saturating stall-cycle counter.
//
// state | meaning
// ------+------------------------------------------------------------------
// RUN   | normal issue; a load-use hazard stalls this cycle
// STALL | extra load-use stall cycles; cnt = remaining STALL cycles after this one
//
// LOAD_LAT must be 1..4. The RUN cycle that detects the hazard is itself the
// first stall cycle, so STALL covers the remaining LOAD_LAT-1 cycles and is
// skipped entirely when LOAD_LAT is 1.
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic           CLK,
    input logic           RST,
    hazard_unit_if.slave  hu
);

    typedef enum logic {RUN, STALL} state_t;

    localparam bit         MULTI_STALL = (LOAD_LAT > 1);
    localparam logic [1:0] CNT_INIT    = 2'(MULTI_STALL ? LOAD_LAT - 2 : 0);

    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              reg_write_e, load_e, reg_write_m, reg_write_w;
    state_t            state;
    logic [1:0]        cnt;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              hz;
    logic              stall;
    logic              flush_e;
    logic [1:0]        fwd_a, fwd_b;

    assign hz = load_e && (rd_e != '0) && ((rd_e == hu.Rs1D) || (rd_e == hu.Rs2D));

    // A taken branch kills the pending stall since the stalled instruction is flushed anyway.
    assign stall   = !hu.PCSrcE && (((state == RUN) && hz) || (state == STALL));
    assign flush_e = stall || hu.PCSrcE;

    assign hu.StallF      = stall;
    assign hu.StallD      = stall;
    assign hu.FlushD      = hu.PCSrcE;
    assign hu.FlushE      = flush_e;
    assign hu.ForwardAE   = fwd_a;
    assign hu.ForwardBE   = fwd_b;
    assign hu.stall_count = stall_cnt_q;

    // Shadow tag pipeline; E takes a bubble whenever the ID/EX register is cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            reg_write_e <= 1'b0;
            load_e      <= 1'b0;
            rd_m        <= '0;
            reg_write_m <= 1'b0;
            rd_w        <= '0;
            reg_write_w <= 1'b0;
        end else begin
            if (flush_e) begin
                rs1_e       <= '0;
                rs2_e       <= '0;
                rd_e        <= '0;
                reg_write_e <= 1'b0;
                load_e      <= 1'b0;
            end else begin
                rs1_e       <= hu.Rs1D;
                rs2_e       <= hu.Rs2D;
                rd_e        <= hu.RdD;
                reg_write_e <= hu.reg_writeD;
                load_e      <= hu.loadD;
            end
            rd_m        <= rd_e;
            reg_write_m <= reg_write_e;
            rd_w        <= rd_m;
            reg_write_w <= reg_write_m;
        end
    end

    // Forwarding selects; the younger M-stage result wins over W.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
            fwd_a = 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
            fwd_a = 2'b01;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
            fwd_b = 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
            fwd_b = 2'b01;
    end

    // Load-use stall sequencer with a down-counter timing the extra stall cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (hu.PCSrcE) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz && MULTI_STALL) begin
                        state <= STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt == 2'd0)
                        state <= RUN;
                    else
                        cnt <= cnt - 2'd1;
                end
                default: begin
                    state <= RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK) begin
        if (RST)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

endmodule
